// File: rtl/tick_sched_if.sv
// Configuration and event handshake bundle for tick_sched.
// master = controller/consumer side, slave = scheduler side.
interface tick_sched_if #(
  parameter int PW = 16,
  parameter int CW = 2
);
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          cfg_oneshot;
  logic          cfg_start;
  logic          evt_valid;
  logic [CW-1:0] evt_ch;
  logic          evt_ready;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_start, evt_ready,
    input  evt_valid, evt_ch
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_start, evt_ready,
    output evt_valid, evt_ch
  );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel ce_in-driven timer scheduler with a round-robin event port.
// Optional sticky overflow flags are built when TICK_SCHED_OVF_EN is defined.
module tick_sched #(
  parameter int N  = 4,
  parameter int PW = 16,
  parameter int CW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce_in,
  tick_sched_if.slave  bus,
  output logic [N-1:0] tick,
  output logic [N-1:0] active,
  output logic [N-1:0] ovf
);

  typedef enum logic [0:0] {IDLE, OFFER} state_t;

  logic [PW-1:0] cnt_r    [N];
  logic [PW-1:0] period_r [N];
  logic [N-1:0]  oneshot_r;
  logic [N-1:0]  active_r;
  logic [N-1:0]  pending_r;
  logic [N-1:0]  tick_r;

  logic [N-1:0]  cfg_hit_s;
  logic [N-1:0]  fire_s;
  logic [N-1:0]  clr_s;
  logic [N-1:0]  pending_nxt_s;
  logic          hs_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          evt_valid_r;
  logic          evt_valid_nxt_s;
  logic [CW-1:0] evt_ch_r;
  logic [CW-1:0] evt_ch_nxt_s;
  logic [CW-1:0] rr_ptr_r;
  logic [CW-1:0] rr_ptr_nxt_s;

  // First requesting channel at or after ptr, wrapping modulo N.
  function automatic logic [CW-1:0] pick_next(input logic [N-1:0] req,
                                              input logic [CW-1:0] ptr);
    logic [CW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] ch);
    if (ch == CW'(N - 1)) begin
      return '0;
    end else begin
      return ch + CW'(1);
    end
  endfunction

  assign hs_s = evt_valid_r & bus.evt_ready;

  // Per-channel decode: config hits, fires, handshake clears and pending update.
  always_comb begin
    cfg_hit_s     = '0;
    fire_s        = '0;
    clr_s         = '0;
    pending_nxt_s = pending_r;
    for (int i = 0; i < N; i++) begin
      cfg_hit_s[i]     = bus.cfg_we && (bus.cfg_ch == CW'(i));
      // A config write on the same channel suppresses the fire.
      fire_s[i]        = ce_in && active_r[i] && (cnt_r[i] == PW'(1)) && !cfg_hit_s[i];
      clr_s[i]         = hs_s && (evt_ch_r == CW'(i));
      pending_nxt_s[i] = fire_s[i] | (pending_r[i] & ~clr_s[i]);
    end
  end

  // Channel counters, configuration registers, pending bits and tick pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i]    <= '0;
        period_r[i] <= '0;
      end
      oneshot_r <= '0;
      active_r  <= '0;
      pending_r <= '0;
      tick_r    <= '0;
    end else begin
      pending_r <= pending_nxt_s;
      tick_r    <= fire_s;
      for (int i = 0; i < N; i++) begin
        if (cfg_hit_s[i]) begin
          if (bus.cfg_start && (bus.cfg_period != '0)) begin
            period_r[i]  <= bus.cfg_period;
            cnt_r[i]     <= bus.cfg_period;
            oneshot_r[i] <= bus.cfg_oneshot;
            active_r[i]  <= 1'b1;
          end else if (bus.cfg_start) begin
            active_r[i] <= 1'b0;
          end else begin
            active_r[i] <= 1'b0;
            cnt_r[i]    <= '0;
          end
        end else if (ce_in && active_r[i]) begin
          if (cnt_r[i] == PW'(1)) begin
            if (oneshot_r[i]) begin
              active_r[i] <= 1'b0;
            end else begin
              cnt_r[i] <= period_r[i];
            end
          end else begin
            cnt_r[i] <= cnt_r[i] - PW'(1);
          end
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      evt_valid_r <= 1'b0;
      evt_ch_r    <= '0;
      rr_ptr_r    <= '0;
    end else begin
      state_r     <= state_nxt_s;
      evt_valid_r <= evt_valid_nxt_s;
      evt_ch_r    <= evt_ch_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
    end
  end

  // Arbiter next state: latch one pending channel, hold it until accepted.
  always_comb begin
    state_nxt_s     = state_r;
    evt_valid_nxt_s = evt_valid_r;
    evt_ch_nxt_s    = evt_ch_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          evt_ch_nxt_s    = pick_next(pending_r, rr_ptr_r);
          evt_valid_nxt_s = 1'b1;
          state_nxt_s     = OFFER;
        end else begin
          evt_valid_nxt_s = 1'b0;
        end
      end
      OFFER: begin
        if (hs_s) begin
          rr_ptr_nxt_s    = next_ch(evt_ch_r);
          evt_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          evt_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        evt_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

`ifdef TICK_SCHED_OVF_EN
  logic [N-1:0] ovf_r;

  // Sticky overflow: a fire landing on an event that is still pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= '0;
    end else begin
      ovf_r <= (ovf_r & ~cfg_hit_s) | (fire_s & pending_r & ~clr_s);
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = '0;
`endif

  assign tick          = tick_r;
  assign active        = active_r;
  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_ch    = evt_ch_r;

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched: periodic, one-shot, round-robin,
// overflow, collisions and mid-operation reset.
module tb_tick_sched;

`ifdef TICK_SCHED_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ce_in;
  logic [3:0] tick;
  logic [3:0] active;
  logic [3:0] ovf;
  int         n_checks;
  int         n_errors;
  logic [1:0] hs_q[$];

  tick_sched_if #(.PW(16), .CW(2)) bus ();

  tick_sched #(.N(4), .PW(16), .CW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce_in  (ce_in),
    .bus    (bus),
    .tick   (tick),
    .active (active),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event.
  always @(posedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) hs_q.push_back(bus.evt_ch);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int period, input logic oneshot, input logic start);
    logic [31:0] c;
    logic [31:0] p;
    c = ch;
    p = period;
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = c[1:0];
    bus.cfg_period  = p[15:0];
    bus.cfg_oneshot = oneshot;
    bus.cfg_start   = start;
    step(1);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic ce_pulse();
    ce_in = 1'b1;
    step(1);
    ce_in = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_tick"}, 32'(tick), 32'h0);
    check_val({tag, "_active"}, 32'(active), 32'h0);
    check_val({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'h0);
    check_val({tag, "_evt_ch"}, 32'(bus.evt_ch), 32'h0);
    check_val({tag, "_ovf"}, 32'(ovf), 32'h0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    ce_in           = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = 2'd0;
    bus.cfg_period  = 16'd0;
    bus.cfg_oneshot = 1'b0;
    bus.cfg_start   = 1'b0;
    bus.evt_ready   = 1'b0;
    step(2);
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // Periodic ch0, period 3, ce every 4 clk.
    bus.evt_ready = 1'b1;
    hs_q.delete();
    cfg_write(0, 3, 1'b0, 1'b1);
    check_val("per_active0", 32'(active[0]), 32'h1);
    for (int n = 1; n <= 9; n++) begin
      ce_pulse();
      check_val($sformatf("per_tick0_ce%0d", n), 32'(tick[0]), (n % 3 == 0) ? 32'h1 : 32'h0);
      step(1);
      check_val($sformatf("per_valid_ce%0d", n), 32'(bus.evt_valid), (n % 3 == 0) ? 32'h1 : 32'h0);
      step(2);
    end
    check_val("per_events", hs_q.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      check_val($sformatf("per_evt_ch%0d", k), (k < hs_q.size()) ? 32'(hs_q[k]) : 32'hff, 32'h0);
    check_val("per_active0_end", 32'(active[0]), 32'h1);
    cfg_write(0, 0, 1'b0, 1'b0);

    // One-shot ch2, period 5.
    hs_q.delete();
    cfg_write(2, 5, 1'b1, 1'b1);
    for (int n = 1; n <= 7; n++) begin
      ce_pulse();
      check_val($sformatf("os_tick2_ce%0d", n), 32'(tick[2]), (n == 5) ? 32'h1 : 32'h0);
      check_val($sformatf("os_active2_ce%0d", n), 32'(active[2]), (n < 5) ? 32'h1 : 32'h0);
      step(3);
    end
    check_val("os_events", hs_q.size(), 32'd1);
    check_val("os_evt_ch", (hs_q.size() > 0) ? 32'(hs_q[0]) : 32'hff, 32'h2);

    // Round-robin from a fresh pointer: all four fire together.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    bus.evt_ready = 1'b0;
    hs_q.delete();
    for (int c = 0; c < 4; c++) cfg_write(c, 1, 1'b0, 1'b1);
    check_val("rr_active", 32'(active), 32'hf);
    ce_pulse();
    check_val("rr_tick", 32'(tick), 32'hf);
    step(20);
    check_val("rr_hold_valid", 32'(bus.evt_valid), 32'h1);
    check_val("rr_hold_ch", 32'(bus.evt_ch), 32'h0);
    bus.evt_ready = 1'b1;
    step(10);
    check_val("rr_events", hs_q.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("rr_order%0d", k), (k < hs_q.size()) ? 32'(hs_q[k]) : 32'hff, 32'(k));
    check_val("rr_valid_end", 32'(bus.evt_valid), 32'h0);
    for (int c = 0; c < 4; c++) cfg_write(c, 0, 1'b0, 1'b0);

    // Overflow on ch1 with the consumer stalled.
    bus.evt_ready = 1'b0;
    hs_q.delete();
    cfg_write(1, 1, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      ce_pulse();
      step(1);
    end
    check_val("ovf_flag1", 32'(ovf[1]), 32'(OVF_EXP));
    check_val("ovf_others", 32'(ovf & 4'b1101), 32'h0);
    check_val("ovf_evt_ch", 32'(bus.evt_ch), 32'h1);
    cfg_write(1, 0, 1'b0, 1'b0);
    check_val("ovf_cleared", 32'(ovf), 32'h0);
    check_val("ovf_stopped", 32'(active[1]), 32'h0);
    check_val("ovf_still_offered", 32'(bus.evt_valid), 32'h1);
    bus.evt_ready = 1'b1;
    step(4);
    check_val("ovf_events", hs_q.size(), 32'd1);
    check_val("ovf_evt_ch_acc", (hs_q.size() > 0) ? 32'(hs_q[0]) : 32'hff, 32'h1);

    // Collision: stop ch0 in its fire cycle.
    hs_q.delete();
    cfg_write(0, 2, 1'b0, 1'b1);
    ce_pulse();
    ce_in           = 1'b1;
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 2'd0;
    bus.cfg_period  = 16'd0;
    bus.cfg_start   = 1'b0;
    step(1);
    ce_in      = 1'b0;
    bus.cfg_we = 1'b0;
    check_val("col_tick0", 32'(tick[0]), 32'h0);
    check_val("col_active0", 32'(active[0]), 32'h0);
    step(3);
    check_val("col_no_event", hs_q.size(), 32'd0);
    check_val("col_no_valid", 32'(bus.evt_valid), 32'h0);

    // Collision: ch1 fires during its own handshake.
    bus.evt_ready = 1'b0;
    cfg_write(1, 1, 1'b0, 1'b1);
    ce_pulse();
    step(2);
    check_val("hsf_valid_pre", 32'(bus.evt_valid), 32'h1);
    check_val("hsf_ch_pre", 32'(bus.evt_ch), 32'h1);
    bus.evt_ready = 1'b1;
    ce_pulse();
    check_val("hsf_tick1", 32'(tick[1]), 32'h1);
    check_val("hsf_valid_gap", 32'(bus.evt_valid), 32'h0);
    step(1);
    check_val("hsf_valid_again", 32'(bus.evt_valid), 32'h1);
    check_val("hsf_ch_again", 32'(bus.evt_ch), 32'h1);
    step(1);
    check_val("hsf_valid_end", 32'(bus.evt_valid), 32'h0);
    check_val("hsf_events", hs_q.size(), 32'd2);
    cfg_write(1, 0, 1'b0, 1'b0);

    // Reset while offering with channels armed.
    bus.evt_ready = 1'b0;
    cfg_write(0, 4, 1'b0, 1'b1);
    cfg_write(3, 1, 1'b0, 1'b1);
    ce_pulse();
    step(2);
    check_val("mid_valid", 32'(bus.evt_valid), 32'h1);
    check_val("mid_ch", 32'(bus.evt_ch), 32'h3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_idle_outputs("mid_reset");
    for (int n = 0; n < 5; n++) begin
      ce_pulse();
      check_val($sformatf("mid_no_tick%0d", n), 32'(tick), 32'h0);
    end
    check_val("mid_no_valid", 32'(bus.evt_valid), 32'h0);
    cfg_write(2, 0, 1'b0, 1'b1);
    check_val("mid_zero_period", 32'(active), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel timer scheduler driven by a shared clock-enable tick, typically 1 kHz from the team's CE generator.
- Each of N channels counts a programmable number of ce_in ticks, then emits a one-cycle tick pulse and queues an event.
- Pending events are serialized onto a single valid/ready event port through a round-robin arbiter.
- Sits between the CE generator and the control FSMs (debounce, display scan, timeouts), which share one event consumer.

Parameters:
N, 4, number of timer channels (2..8)
PW, 16, period/counter width in ce_in ticks
CW, 2, channel index width; must satisfy 2**CW >= N

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
ce_in  input  1  one-cycle tick enable from the CE generator
cfg_we  input  1  configuration write strobe
cfg_ch  input  CW  channel addressed by cfg_we
cfg_period  input  PW  period in ce_in ticks
cfg_oneshot  input  1  1 = one-shot, 0 = periodic
cfg_start  input  1  1 = load and arm the channel, 0 = stop the channel
tick  output  N  per-channel one-cycle fire pulse
active  output  N  channel armed
evt_valid  output  1  event offered
evt_ch  output  CW  channel of the offered event
evt_ready  input  1  consumer accepts the event
ovf  output  N  sticky overflow per channel (optional feature)

Behaviour:
- Reset, synchronous, when rst_n=0 at a clk edge: tick=0, active=0, evt_valid=0, evt_ch=0, ovf=0. All counters, periods, pending bits and the round-robin pointer are cleared; arbiter state is IDLE.
- Config write (cfg_we=1, cfg_ch<N):
  - cfg_start=1 and cfg_period!=0: period[ch]=cnt[ch]=cfg_period, oneshot[ch]=cfg_oneshot, active[ch]=1.
  - cfg_start=1 and cfg_period=0: channel stopped, active=0.
  - cfg_start=0: active[ch]=0, cnt[ch]=0. pending[ch] is left unchanged.
  - cfg_ch>=N: write ignored.
- Counting: on each ce_in=1 with active[i]=1:
  - cnt[i]==1 is a fire. Periodic: cnt reloads from period. One-shot: active[i]=0.
  - Otherwise cnt[i] decrements.
  - The first fire comes exactly period ce_in ticks after arming. Inactive channels hold cnt.
- Fire latency: ce_in at edge k causes tick[i]=1 for exactly the cycle after edge k, and pending[i] is set at edge k.
- Config write and fire on the same channel in the same cycle: the config write wins and no fire occurs.
- Arbiter FSM:
  - IDLE: if any pending bit is set, latch evt_ch = first pending channel at or after rr_ptr (wrapping modulo N), set evt_valid=1, go to OFFER.
  - OFFER: evt_valid and evt_ch are held stable until evt_ready=1. On handshake, clear pending[evt_ch], set rr_ptr=(evt_ch+1) mod N, evt_valid=0, go to IDLE.
  - Throughput is at most one event per 2 cycles.
- Handshake clear and new fire on the same channel in the same cycle: the new fire wins and pending stays 1.
- Stopping a channel does not withdraw an event that is already pending or being offered.
- Back-to-back fires of a channel whose pending bit is still 1 merge into one event; see the optional feature.

Optional Feature:
- Macro TICK_SCHED_OVF_EN.
- Defined: ovf[i] sets when channel i fires while pending[i]=1 and is not being cleared in that cycle. ovf[i] is sticky and clears only on a config write to channel i or on reset.
- Undefined: the ovf port exists and is tied to 0, and no overflow logic is built.

Test Plan:
- Periodic: ch0 period=3, ce_in every 4 clk → tick[0] pulses after ce ticks 3, 6, 9. evt_valid is raised and evt_ch=0 accepted with evt_ready=1; active[0] stays 1.
- One-shot: ch2 period=5, oneshot=1 → exactly one tick[2] after the 5th ce_in, active[2]=0 afterwards, one event with evt_ch=2.
- Round-robin: ch0..ch3 all period=1, evt_ready=0 for 20 clk, then 1 → evt_ch sequence 0, 1, 2, 3, each pending cleared once.
- Overflow: ch1 period=1, evt_ready=0, 3 ce_in → with macro, ovf[1]=1 and only one event; without macro, ovf=0. A config write to ch1 clears ovf[1].
- Collisions: cfg_we stop on ch0 in its fire cycle → no tick[0]. Fire on ch1 during its own handshake → evt_valid reasserts for ch1 within 2 clk.
- Reset mid-operation: rst_n=0 for 1 clk while in OFFER with counters armed → all outputs 0 the next cycle. No ticks until reconfigured; period=0 writes leave active=0.
